// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and parity modes.
// Used by the receiver today and by the transmitter later.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_rx_sampler.sv
// Synchroniser, per-bit timebase and 2-of-3 majority vote around mid-bit.
// bit_strobe marks the cycle in which bit_val holds the voted bit.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic clk,
  input  logic nrst,
  input  logic rx,
  input  logic run,
  output logic rxs,
  output logic bit_strobe,
  output logic bit_val
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SAMP_A   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] SAMP_B   = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] SAMP_C   = CW'(CLKS_PER_BIT / 2 + 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic          samp_a, samp_b;

  // counter sits at 0 while idle so the start-detect cycle is count 0
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      cnt    <= '0;
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      if (!run || cnt == CNT_LAST) cnt <= '0;
      else                         cnt <= cnt + CW'(1);
      if (cnt == SAMP_A) samp_a <= sync2;
      if (cnt == SAMP_B) samp_b <= sync2;
    end
  end

  assign rxs        = sync2;
  assign bit_strobe = (cnt == SAMP_C);
  assign bit_val    = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);

endmodule

// File: rtl/uartrx_param.sv
// Parametrised UART receiver: start/data/parity/stop framing, error flags,
// and a valid/ready output register that drops new frames while full.
module uartrx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [2:0]           out_state
);

  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic       PAR_EN    = (PARITY != PAR_NONE);

  rx_state_t state_q, state_d;
  logic rxs, bit_strobe, bit_val;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0] data_cnt;
  logic stop_cnt, par_acc, ferr_pend, perr_pend;
  logic frame_done, can_load;

  uart_rx_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .clk        (clk),
    .nrst       (nrst),
    .rx         (rx),
    .run        (state_d != ST_IDLE),
    .rxs        (rxs),
    .bit_strobe (bit_strobe),
    .bit_val    (bit_val)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    if (state_q != ST_IDLE && !en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (en && !rxs) state_d = ST_START;
        ST_START:  if (bit_strobe) state_d = bit_val ? ST_IDLE : ST_DATA;
        ST_DATA:   if (bit_strobe && data_cnt == DATA_LAST)
                     state_d = PAR_EN ? ST_PARITY : ST_STOP;
        ST_PARITY: if (bit_strobe) state_d = ST_STOP;
        ST_STOP:   if (bit_strobe && stop_cnt == STOP_LAST) begin
                     state_d    = ST_IDLE;
                     frame_done = 1'b1;
                   end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  assign can_load = !dout_valid || dout_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shreg      <= '0;
      data_cnt   <= '0;
      stop_cnt   <= 1'b0;
      par_acc    <= 1'b0;
      ferr_pend  <= 1'b0;
      perr_pend  <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= frame_done && !can_load;
      // the last stop bit's sample is folded straight into frame_err
      if (frame_done && can_load) begin
        dout       <= shreg;
        frame_err  <= ferr_pend | ~bit_val;
        parity_err <= perr_pend;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      case (state_q)
        ST_START: begin
          data_cnt  <= '0;
          stop_cnt  <= 1'b0;
          par_acc   <= 1'b0;
          ferr_pend <= 1'b0;
          perr_pend <= 1'b0;
        end
        ST_DATA: if (bit_strobe) begin
          shreg    <= {bit_val, shreg[DATA_BITS-1:1]};
          par_acc  <= par_acc ^ bit_val;
          data_cnt <= data_cnt + 4'd1;
        end
        ST_PARITY: if (bit_strobe) begin
          perr_pend <= (PARITY == PAR_ODD) ? ~(par_acc ^ bit_val) : (par_acc ^ bit_val);
        end
        ST_STOP: if (bit_strobe) begin
          stop_cnt  <= stop_cnt + 1'b1;
          ferr_pend <= ferr_pend | ~bit_val;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign out_state = state_q;

endmodule

// File: tb/tb_uartrx_param.sv
// Bench for uartrx_param: three receivers (8N1, 8O1, 8E1) at 16 clocks/bit,
// frames modelled from the line protocol and checked through a scoreboard.
module tb_uartrx_param;

  localparam int C = 16;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    int         rise;
  } exp_t;

  logic       clk = 1'b0;
  logic       nrst;
  logic       rx    [3];
  logic       en    [3];
  logic       ready [3];
  logic [7:0] dout  [3];
  logic       dv    [3];
  logic       fe    [3];
  logic       pe    [3];
  logic       ov    [3];
  logic       busy  [3];
  logic [2:0] st    [3];

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   ov_cnt [3];
  int   ov_exp [3];
  logic prev_dv [3];
  exp_t exp_q [3][$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uartrx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(g), .STOP_BITS(1)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .en         (en[g]),
      .rx         (rx[g]),
      .dout       (dout[g]),
      .dout_valid (dv[g]),
      .dout_ready (ready[g]),
      .frame_err  (fe[g]),
      .parity_err (pe[g]),
      .overrun    (ov[g]),
      .busy       (busy[g]),
      .out_state  (st[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: actual=%0h required=%0h (cycle %0d)", name, g, act, req, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame on DUT g, starting right after a rising edge.
  task automatic send(input int g, input logic [7:0] d, input logic pbit, input logic stop_v,
                      input int glitch_bit, input bit push, input bit timed);
    logic bits [12];
    int   n;
    int   ones;
    exp_t e;
    n = 0;
    bits[n] = 1'b0; n = n + 1;
    for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n = n + 1; end
    if (g != 0) begin bits[n] = pbit; n = n + 1; end
    bits[n] = stop_v; n = n + 1;
    ones = $countones(d) + ((g != 0) ? int'(pbit) : 0);
    e.d    = d;
    e.fe   = !stop_v;
    e.pe   = (g == 1) ? (ones % 2 == 0) : (g == 2) ? (ones % 2 == 1) : 1'b0;
    // start detected 2 cycles after the pin (synchroniser)
    e.rise = timed ? (cyc + 2) + (n - 1) * C + C / 2 + 2 : -1;
    if (push) exp_q[g].push_back(e);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < C; j++) begin
        rx[g] = (k == glitch_bit && j == C / 2) ? ~bits[k] : bits[k];
        @(posedge clk); #1;
      end
    rx[g] = 1'b1;
  endtask

  task automatic check_reset_vals(input string name, input int g);
    check(name, g, {16'd0, dout[g], dv[g], fe[g], pe[g], ov[g], busy[g], st[g]}, 32'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (!nrst) begin
          prev_dv[g] = 1'b0;
        end else begin
          if (ov[g]) ov_cnt[g]++;
          if (dv[g]) begin
            if (exp_q[g].size() == 0) begin
              check("unexpected_word", g, {24'd0, dout[g]}, 32'hFFFF_FFFF);
            end else begin
              e = exp_q[g][0];
              if (!prev_dv[g] && e.rise >= 0) check("valid_rise_cycle", g, cyc, e.rise);
              if (ready[g]) begin
                check("word_dout_fe_pe", g, {dout[g], fe[g], pe[g]}, {e.d, e.fe, e.pe});
                void'(exp_q[g].pop_front());
              end else begin
                check("held_word_stable", g, {24'd0, dout[g]}, {24'd0, e.d});
              end
            end
          end
          prev_dv[g] = dv[g];
        end
      end
    end
  endtask

  task automatic main_seq();
    logic [7:0] d;
    logic       p;
    nrst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      rx[g] = 1'b1; en[g] = 1'b1; ready[g] = 1'b1;
      ov_cnt[g] = 0; ov_exp[g] = 0; prev_dv[g] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) check_reset_vals("reset_outputs", g);
    nrst = 1'b1;
    idle(3);

    // 8N1 back-to-back with latency check
    send(0, 8'h45, 1'b0, 1'b1, -1, 1, 1);
    send(0, 8'hD6, 1'b0, 1'b1, -1, 1, 1);
    idle(20);

    // parity, both parity bit values, odd and even DUTs
    for (int g = 1; g < 3; g++) begin
      send(g, 8'h45, 1'b1, 1'b1, -1, 1, 1);
      send(g, 8'h45, 1'b0, 1'b1, -1, 1, 1);
      idle(20);
    end

    // random back-to-back frames, random parity bit
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 4; i++) begin
        d = 8'($urandom_range(0, 255));
        p = 1'($urandom_range(0, 1));
        send(g, d, p, 1'b1, -1, 1, 1);
      end
      idle(20);
    end

    // false start: 3-cycle low pulse
    rx[0] = 1'b0;
    idle(3);
    rx[0] = 1'b1;
    check("false_start_busy", 0, {31'd0, busy[0]}, 32'd1);
    idle(C);
    check("false_start_idle", 0, {29'd0, st[0]}, 32'd0);

    // one-cycle glitch in the middle of data bit 3 (frame index 4)
    send(0, 8'hB9, 1'b0, 1'b1, 4, 1, 1);
    idle(10);

    // stop bit held low
    send(0, 8'h3C, 1'b0, 1'b0, -1, 1, 1);
    idle(3 * C);

    // overrun with consumer stalled
    ready[0] = 1'b0;
    send(0, 8'h11, 1'b0, 1'b1, -1, 1, 1);
    send(0, 8'h22, 1'b0, 1'b1, -1, 0, 0);
    ov_exp[0]++;
    idle(4);
    check("overrun_pulses", 0, ov_cnt[0], ov_exp[0]);
    ready[0] = 1'b1;
    idle(1);
    check("valid_falls_on_accept", 0, {31'd0, dv[0]}, 32'd0);
    idle(10);

    // enable dropped mid-DATA, then a clean frame
    rx[1] = 1'b0;
    idle(C);
    for (int k = 0; k < 4; k++) begin
      rx[1] = k[0];
      idle(C);
    end
    check("abort_in_data", 1, {29'd0, st[1]}, 32'd2);
    en[1] = 1'b0;
    idle(1);
    check("abort_to_idle", 1, {31'd0, busy[1]}, 32'd0);
    rx[1] = 1'b1;
    idle(2);
    en[1] = 1'b1;
    idle(2 * C);
    send(1, 8'h5A, 1'b1, 1'b1, -1, 1, 1);
    idle(10);

    // asynchronous reset mid-frame while a word is held
    ready[2] = 1'b0;
    send(2, 8'hA5, 1'b0, 1'b1, -1, 1, 1);
    rx[2] = 1'b0;
    idle(C + 3 * C / 2);
    nrst = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check_reset_vals("async_reset", g);
      exp_q[g].delete();
    end
    #20;
    rx[2] = 1'b1;
    ready[2] = 1'b1;
    @(posedge clk); #1;
    nrst = 1'b1;
    idle(2 * C);
    send(2, 8'h5A, 1'b0, 1'b1, -1, 1, 1);
    idle(10);

    for (int g = 0; g < 3; g++) begin
      check("queue_drained", g, exp_q[g].size(), 32'd0);
      check("overrun_total", g, ov_cnt[g], ov_exp[g]);
    end
  endtask

  initial begin
    fork
      monitor();
      main_seq();
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
